// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the sequencing state encoding used by the
// basemul host and, later, the NTT datapath.
package kyber_pkg;

    localparam int N = 256;
    localparam int W = 12;
    localparam int Q = 3329;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_P = 3'd1,
        ST_LOAD_Q = 3'd2,
        ST_FIRE   = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SEND   = 3'd5
    } state_e;

endpackage

// File: rtl/coef_cond_sub.sv
// Single conditional subtraction of Q. This fully reduces any W-bit input
// because 2^W - 1 - Q < Q for the Kyber parameters.
module coef_cond_sub #(
    parameter int W = kyber_pkg::W,
    parameter int Q = kyber_pkg::Q
) (
    input  logic [W-1:0] coef_i,
    output logic [W-1:0] coef_o
);

    localparam logic [W-1:0] QW = W'(Q);

    assign coef_o = (coef_i >= QW) ? (coef_i - QW) : coef_i;

endmodule

// File: rtl/basemul_host.sv
// Streams p and q into packed registers, fires the basemul unit once, and
// streams the captured result back out.
//   state   | meaning
//   IDLE    | waiting for i_start
//   LOAD_P  | accepting p coefficients into p_q[idx]
//   LOAD_Q  | accepting q coefficients into q_q[idx]
//   FIRE    | o_bm_en high for one cycle
//   WAIT    | waiting for i_bm_done, result captured on that edge
//   SEND    | streaming res_q[idx] out
module basemul_host #(
    parameter int N = kyber_pkg::N,
    parameter int W = kyber_pkg::W,
    parameter int Q = kyber_pkg::Q
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_start,
    input  logic           i_coef_valid,
    input  logic [W-1:0]   i_coef,
    output logic           o_coef_ready,
    output logic [N*W-1:0] o_bm_p,
    output logic [N*W-1:0] o_bm_q,
    output logic           o_bm_en,
    input  logic           i_bm_done,
    input  logic [N*W-1:0] i_bm_result,
    output logic           o_res_valid,
    output logic [W-1:0]   o_res,
    input  logic           i_res_ready,
    output logic           o_busy,
    output logic           o_done
);

    import kyber_pkg::*;

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            done_q, done_d;
    logic [N*W-1:0]  p_q, q_q, res_q;
    logic [W-1:0]    coef_red;
    logic            coef_accept, res_accept, idx_last;

    coef_cond_sub #(.W(W), .Q(Q)) u_cond_sub (
        .coef_i (i_coef),
        .coef_o (coef_red)
    );

    // Handshake outputs are pure state decodes, no path from valid/ready.
    assign o_coef_ready = (state_q == ST_LOAD_P) || (state_q == ST_LOAD_Q);
    assign o_res_valid  = (state_q == ST_SEND);
    assign o_bm_en      = (state_q == ST_FIRE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = done_q;
    assign o_bm_p       = p_q;
    assign o_bm_q       = q_q;
    assign o_res        = res_q[idx_q*W +: W];

    assign coef_accept  = i_coef_valid && o_coef_ready;
    assign res_accept   = o_res_valid && i_res_ready;
    assign idx_last     = (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD_P;
                    idx_d   = '0;
                end
            end
            ST_LOAD_P: begin
                if (coef_accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_LOAD_Q;
                    end
                end
            end
            ST_LOAD_Q: begin
                if (coef_accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_bm_done) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (res_accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Result is sampled only on the WAIT-state done edge; stray dones are dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            p_q   <= '0;
            q_q   <= '0;
            res_q <= '0;
        end else begin
            if (coef_accept && (state_q == ST_LOAD_P)) begin
                p_q[idx_q*W +: W] <= coef_red;
            end
            if (coef_accept && (state_q == ST_LOAD_Q)) begin
                q_q[idx_q*W +: W] <= coef_red;
            end
            if ((state_q == ST_WAIT) && i_bm_done) begin
                res_q <= i_bm_result;
            end
        end
    end

endmodule
